// File: rtl/tms_pulse_sequencer.sv
// rtl/tms_pulse_sequencer.sv - IGBT/SCR pulse-train sequencer with fault shutdown
module tms_pulse_sequencer #(
    parameter int CLK_PER_US = 50,
    parameter int N_IGBT     = 5
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              fault,
    input  logic [N_IGBT-1:0] ch_en,
    input  logic [23:0]       igbt_on_us,
    input  logic [15:0]       scr_delay_us,
    input  logic [15:0]       scr_on_us,
    input  logic [23:0]       pulse_period_us,
    input  logic [7:0]        pulses_per_burst,
    input  logic [23:0]       burst_period_us,
    input  logic [7:0]        bursts_per_train,
    output logic [N_IGBT-1:0] igbt,
    output logic              scr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              fault_abort,
    output logic [7:0]        pulse_cnt,
    output logic [7:0]        burst_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_IGBT_ON   = 3'd1;
    localparam logic [2:0] S_SCR_WAIT  = 3'd2;
    localparam logic [2:0] S_SCR_ON    = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_BURST_GAP = 3'd5;

    localparam int          PW        = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_US - 1);
    localparam logic [31:0] CYC_PER_US = 32'(CLK_PER_US);

    logic [2:0]        state_q, state_d;
    logic [PW-1:0]     presc_q;
    logic [23:0]       us_q;
    logic [31:0]       pt_q, bt_q;
    logic              stop_q;

    logic [N_IGBT-1:0] ch_q;
    logic [23:0]       ion_q, per_q, bper_q;
    logic [15:0]       sdly_q, son_q;
    logic [7:0]        ppb_q, bpt_q;

    logic [N_IGBT-1:0] igbt_q;
    logic              scr_q, busy_q, done_q, cfg_err_q, fault_abort_q;
    logic [7:0]        pulse_cnt_q, burst_cnt_q;

    logic              cfg_ok, stop_now, ph_end, period_hit, burst_hit;
    logic [23:0]       ph_len;
    logic [2:0]        adv_state;
    logic              adv_pulse, adv_burst, adv_finish;
    logic              accept, pulse_start, burst_start, active_end, enter;
    logic              done_d, cfg_err_d, abort_d;
    logic [31:0]       per_cyc, bper_cyc;

    assign cfg_ok     = (|ch_en) && (|igbt_on_us) && (|pulses_per_burst) && (|bursts_per_train);
    assign stop_now   = stop || stop_q;
    assign per_cyc    = 32'(per_q) * CYC_PER_US;
    assign bper_cyc   = 32'(bper_q) * CYC_PER_US;
    // Timers hold the cycle index since the pulse/burst rising edge; "hit" means the next edge is due.
    assign period_hit = (pt_q + 32'd1) >= per_cyc;
    assign burst_hit  = (bt_q + 32'd1) >= bper_cyc;

    // Length in us of the phase currently being timed.
    always_comb begin
        ph_len = 24'd0;
        case (state_q)
            S_IGBT_ON:  ph_len = ion_q;
            S_SCR_WAIT: ph_len = {8'd0, sdly_q};
            S_SCR_ON:   ph_len = {8'd0, son_q};
            default:    ph_len = 24'd0;
        endcase
    end

    // A zero-length dead time still occupies one cycle, so the phase ends on its first cycle.
    assign ph_end = (ph_len == 24'd0) || ((presc_q == PRESC_MAX) && (us_q == ph_len - 24'd1));

    // Where the sequence goes once the current pulse period has been satisfied.
    always_comb begin
        adv_state  = S_BURST_GAP;
        adv_pulse  = 1'b0;
        adv_burst  = 1'b0;
        adv_finish = 1'b0;
        if (pulse_cnt_q < ppb_q) begin
            adv_state = S_IGBT_ON;
            adv_pulse = 1'b1;
        end else if (burst_cnt_q == bpt_q) begin
            adv_state  = S_IDLE;
            adv_finish = 1'b1;
        end else if (burst_hit) begin
            adv_state = S_IGBT_ON;
            adv_pulse = 1'b1;
            adv_burst = 1'b1;
        end
    end

    // Next-state logic; fault overrides every other decision.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        pulse_start = 1'b0;
        burst_start = 1'b0;
        active_end  = 1'b0;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        abort_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !fault) begin
                    if (cfg_ok) begin
                        accept      = 1'b1;
                        state_d     = S_IGBT_ON;
                        pulse_start = 1'b1;
                        burst_start = 1'b1;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_IGBT_ON: begin
                if (ph_end) begin
                    if (son_q != 16'd0) state_d = S_SCR_WAIT;
                    else                active_end = 1'b1;
                end
            end
            S_SCR_WAIT: begin
                if (ph_end) state_d = S_SCR_ON;
            end
            S_SCR_ON: begin
                if (ph_end) active_end = 1'b1;
            end
            S_GAP: begin
                if (stop_now) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (period_hit) begin
                    state_d     = adv_state;
                    pulse_start = adv_pulse;
                    burst_start = adv_burst;
                    done_d      = adv_finish;
                end
            end
            S_BURST_GAP: begin
                if (stop_now) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (burst_hit) begin
                    state_d     = S_IGBT_ON;
                    pulse_start = 1'b1;
                    burst_start = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // End of the active phases: skip GAP entirely when the period is already used up.
        if (active_end) begin
            if (stop_now) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else if (!period_hit) begin
                state_d = S_GAP;
            end else begin
                state_d     = adv_state;
                pulse_start = adv_pulse;
                burst_start = adv_burst;
                done_d      = adv_finish;
            end
        end
        if ((state_q != S_IDLE) && fault) begin
            state_d     = S_IDLE;
            pulse_start = 1'b0;
            burst_start = 1'b0;
            done_d      = 1'b0;
            abort_d     = 1'b1;
        end
    end

    assign enter = (state_d != state_q) || pulse_start;

    // State, timers, latched configuration and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= S_IDLE;
            presc_q       <= '0;
            us_q          <= '0;
            pt_q          <= '0;
            bt_q          <= '0;
            stop_q        <= 1'b0;
            ch_q          <= '0;
            ion_q         <= '0;
            sdly_q        <= '0;
            son_q         <= '0;
            per_q         <= '0;
            ppb_q         <= '0;
            bper_q        <= '0;
            bpt_q         <= '0;
            igbt_q        <= '0;
            scr_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
            fault_abort_q <= 1'b0;
            pulse_cnt_q   <= '0;
            burst_cnt_q   <= '0;
        end else begin
            state_q <= state_d;

            if (enter || (state_q == S_IDLE)) begin
                presc_q <= '0;
                us_q    <= '0;
            end else if (presc_q == PRESC_MAX) begin
                presc_q <= '0;
                us_q    <= us_q + 24'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            if (pulse_start)      pt_q <= '0;
            else if (pt_q != '1)  pt_q <= pt_q + 32'd1;
            if (burst_start)      bt_q <= '0;
            else if (bt_q != '1)  bt_q <= bt_q + 32'd1;

            if (state_d == S_IDLE)                  stop_q <= 1'b0;
            else if (stop && (state_q != S_IDLE))   stop_q <= 1'b1;

            if (accept) begin
                ch_q   <= ch_en;
                ion_q  <= igbt_on_us;
                sdly_q <= scr_delay_us;
                son_q  <= scr_on_us;
                per_q  <= pulse_period_us;
                ppb_q  <= pulses_per_burst;
                bper_q <= burst_period_us;
                bpt_q  <= bursts_per_train;
            end

            if (pulse_start) pulse_cnt_q <= burst_start ? 8'd1 : pulse_cnt_q + 8'd1;
            if (burst_start) burst_cnt_q <= accept ? 8'd1 : burst_cnt_q + 8'd1;

            igbt_q    <= (state_d == S_IGBT_ON) ? (accept ? ch_en : ch_q) : '0;
            scr_q     <= (state_d == S_SCR_ON);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            if (accept)       fault_abort_q <= 1'b0;
            else if (abort_d) fault_abort_q <= 1'b1;
        end
    end

    assign igbt        = igbt_q;
    assign scr         = scr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cfg_err     = cfg_err_q;
    assign fault_abort = fault_abort_q;
    assign pulse_cnt   = pulse_cnt_q;
    assign burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_tms_pulse_sequencer.sv
// tb/tb_tms_pulse_sequencer.sv - scoreboard bench for tms_pulse_sequencer
module tb_tms_pulse_sequencer;

    localparam int C = 50;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, fault = 1'b0;
    logic [4:0]  ch_en = '0;
    logic [23:0] igbt_on_us = '0, pulse_period_us = '0, burst_period_us = '0;
    logic [15:0] scr_delay_us = '0, scr_on_us = '0;
    logic [7:0]  pulses_per_burst = '0, bursts_per_train = '0;
    logic [4:0]  igbt;
    logic        scr, busy, done, cfg_err, fault_abort;
    logic [7:0]  pulse_cnt, burst_cnt;

    tms_pulse_sequencer #(.CLK_PER_US(C), .N_IGBT(5)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop), .fault(fault),
        .ch_en(ch_en), .igbt_on_us(igbt_on_us), .scr_delay_us(scr_delay_us), .scr_on_us(scr_on_us),
        .pulse_period_us(pulse_period_us), .pulses_per_burst(pulses_per_burst),
        .burst_period_us(burst_period_us), .bursts_per_train(bursts_per_train),
        .igbt(igbt), .scr(scr), .busy(busy), .done(done), .cfg_err(cfg_err),
        .fault_abort(fault_abort), .pulse_cnt(pulse_cnt), .burst_cnt(burst_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct { int kind; int cyc; int val; } ev_t;
    ev_t expq[$];
    int  checks = 0, failures = 0;
    int  rise_log[$];
    int  done_cnt = 0, last_done = 0;
    bit  mon_en = 0, overlap_seen = 0;
    logic [4:0] prev_igbt = '0;
    logic prev_scr = 1'b0, prev_fa = 1'b0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic push_ev(input int k, input int c, input int v);
        ev_t e;
        e.kind = k; e.cyc = c; e.val = v;
        expq.push_back(e);
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d val=%h", k, cyc, v);
        end else begin
            e = expq.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                failures++;
                $display("FAIL event got kind=%0d cyc=%0d val=%h expected kind=%0d cyc=%0d val=%h",
                         k, cyc, v, e.kind, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: every output change or strobe is matched against the scoreboard queue.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (igbt != prev_igbt) begin
                if (prev_igbt == '0) rise_log.push_back(cyc);
                observe(0, int'(igbt) | (int'(pulse_cnt) << 8) | (int'(burst_cnt) << 16));
            end
            if (scr != prev_scr) observe(1, int'(scr));
            if (done) begin
                done_cnt++;
                last_done = cyc;
                observe(2, int'(pulse_cnt) | (int'(burst_cnt) << 8) | (int'(busy) << 16));
            end
            if (cfg_err) observe(3, int'(busy));
            if (fault_abort && !prev_fa)
                observe(4, int'(pulse_cnt) | (int'(burst_cnt) << 8) | (int'(busy) << 16));
            if ((|igbt) && scr) overlap_seen = 1;
        end
        prev_igbt = igbt;
        prev_scr  = scr;
        prev_fa   = fault_abort;
    end

    // Reference model: builds the pulse schedule arithmetically, then derives expected output events.
    task automatic model(input int t0, input int sa, input int fa, output int term);
        int ig_c, w_c, s_c, p_c, b_c, np, nb, chv;
        int r, b, e, a, end_c, cp, cb, ig, sc, pig, psc;
        bit dn;
        int rs[$], ae[$], pcq[$], bcq[$];
        chv  = int'(ch_en);
        ig_c = int'(igbt_on_us) * C;
        w_c  = (scr_delay_us == 0) ? 1 : int'(scr_delay_us) * C;
        s_c  = int'(scr_on_us) * C;
        p_c  = int'(pulse_period_us) * C;
        b_c  = int'(burst_period_us) * C;
        np   = int'(pulses_per_burst);
        nb   = int'(bursts_per_train);
        r = t0 + 1; b = r; e = r;
        for (int bi = 1; bi <= nb; bi++) begin
            for (int pi = 1; pi <= np; pi++) begin
                a = r + ig_c + ((s_c > 0) ? w_c + s_c : 0);
                rs.push_back(r); ae.push_back(a); pcq.push_back(pi); bcq.push_back(bi);
                e = (r + p_c > a) ? r + p_c : a;
                r = e;
            end
            if (bi < nb) begin
                r = (b + b_c > e) ? b + b_c : e;
                b = r;
            end
        end
        end_c = e;
        term = end_c; dn = 1;
        if (fa > 0 && fa < end_c) begin
            term = fa + 1; dn = 0;
        end else if (sa > 0 && sa < end_c) begin
            term = sa + 1;
            foreach (rs[k]) if (sa >= rs[k] && sa < ae[k]) term = ae[k];
        end
        pig = 0; psc = 0;
        for (int c = t0 + 1; c <= term; c++) begin
            ig = 0; sc = 0; cp = 0; cb = 0;
            foreach (rs[k]) begin
                if (rs[k] <= c && rs[k] < term) begin
                    cp = pcq[k]; cb = bcq[k];
                    if (c < term && c < rs[k] + ig_c) ig = chv;
                    if (c < term && s_c > 0 && c >= rs[k] + ig_c + w_c && c < ae[k]) sc = 1;
                end
            end
            if (ig != pig) push_ev(0, c, ig | (cp << 8) | (cb << 16));
            if (sc != psc) push_ev(1, c, sc);
            if (c == term) push_ev(dn ? 2 : 4, c, cp | (cb << 8));
            pig = ig; psc = sc;
        end
    endtask

    task automatic set_cfg(input logic [4:0] ch, input int ion, input int dly, input int son,
                           input int per, input int ppb, input int bper, input int bpt);
        ch_en = ch; igbt_on_us = 24'(ion); scr_delay_us = 16'(dly); scr_on_us = 16'(son);
        pulse_period_us = 24'(per); pulses_per_burst = 8'(ppb);
        burst_period_us = 24'(bper); bursts_per_train = 8'(bpt);
    endtask

    task automatic run(input int stop_off, input int fault_off, input bit poke, output int t0);
        int term, sa, fa, n;
        rise_log.delete();
        @(negedge sys_clk);
        t0 = cyc;
        sa = (stop_off > 0) ? t0 + stop_off : 0;
        fa = (fault_off > 0) ? t0 + fault_off : 0;
        model(t0, sa, fa, term);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        // Inputs change during the run; the design must keep using the latched copy.
        ch_en = 5'($urandom); igbt_on_us = 24'($urandom); scr_on_us = 16'($urandom);
        pulse_period_us = 24'($urandom); pulses_per_burst = 8'($urandom);
        n = 0;
        while (expq.size() != 0 && n < 20000) begin
            stop  = (cyc == sa);
            fault = (cyc == fa);
            start = poke && (cyc == t0 + 2);
            @(negedge sys_clk);
            n++;
        end
        stop = 1'b0; fault = 1'b0; start = 1'b0;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL run_timeout pending=%0d expected=0", expq.size());
            expq.delete();
        end
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic reject(input string name);
        @(negedge sys_clk);
        push_ev(3, cyc + 1, 0);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (4) @(negedge sys_clk);
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL %s_cfg_err_missing pending=%0d expected=0", name, expq.size());
            expq.delete();
        end
        chk({name, "_busy"}, busy, 0);
        chk({name, "_igbt"}, igbt, 0);
    endtask

    initial begin
        int t0, dc, mode, off;
        int exp_r[6];
        repeat (3) @(negedge sys_clk);
        chk("reset_igbt", igbt, 0);
        chk("reset_scr", scr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_fault_abort", fault_abort, 0);
        chk("reset_pulse_cnt", pulse_cnt, 0);
        chk("reset_burst_cnt", burst_cnt, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        mon_en = 1;

        // Single pulse
        set_cfg(5'b00001, 2, 1, 3, 10, 1, 20, 1);
        run(0, 0, 0, t0);
        chk("single_done_offset", last_done - t0, 501);
        chk("single_rise_count", rise_log.size(), 1);

        // Train with a start poked mid-run
        set_cfg(5'h1F, 1, 0, 0, 4, 3, 20, 2);
        dc = done_cnt;
        run(0, 0, 1, t0);
        exp_r = '{1, 201, 401, 1001, 1201, 1401};
        chk("train_rise_count", rise_log.size(), 6);
        for (int i = 0; i < 6 && i < rise_log.size(); i++) chk("train_rise", rise_log[i] - t0, exp_r[i]);
        chk("train_burst_cnt", burst_cnt, 2);
        chk("train_pulse_cnt", pulse_cnt, 3);
        chk("train_done_once", done_cnt - dc, 1);

        // Period clamp
        set_cfg(5'b00100, 2, 0, 1, 1, 2, 1, 1);
        run(0, 0, 0, t0);
        chk("clamp_rise_count", rise_log.size(), 2);
        if (rise_log.size() == 2) chk("clamp_spacing", rise_log[1] - rise_log[0], 151);

        // Fault during IGBT_ON, then a clean rerun
        set_cfg(5'b00001, 2, 1, 3, 10, 1, 20, 1);
        dc = done_cnt;
        run(0, 40, 0, t0);
        chk("fault_abort_set", fault_abort, 1);
        chk("fault_busy", busy, 0);
        chk("fault_no_done", done_cnt - dc, 0);
        set_cfg(5'b00001, 2, 1, 3, 10, 1, 20, 1);
        run(0, 0, 0, t0);
        chk("fault_abort_cleared", fault_abort, 0);
        chk("rerun_done", done_cnt - dc, 1);

        // Stop in SCR_WAIT, then stop in GAP
        set_cfg(5'b00011, 2, 1, 3, 10, 3, 40, 1);
        run(120, 0, 0, t0);
        chk("stop_wait_done_offset", last_done - t0, 301);
        chk("stop_wait_rises", rise_log.size(), 1);
        set_cfg(5'b00011, 2, 1, 3, 10, 3, 40, 1);
        run(400, 0, 0, t0);
        chk("stop_gap_done_offset", last_done - t0, 401);

        // Rejections and a start masked by fault
        set_cfg(5'b00001, 2, 1, 3, 10, 0, 20, 1);
        reject("rej_ppb0");
        set_cfg(5'b00000, 2, 1, 3, 10, 1, 20, 1);
        reject("rej_ch0");
        set_cfg(5'b00001, 2, 1, 3, 10, 1, 20, 1);
        @(negedge sys_clk);
        start = 1'b1; fault = 1'b1;
        @(negedge sys_clk);
        start = 1'b0; fault = 1'b0;
        repeat (5) @(negedge sys_clk);
        chk("start_with_fault_busy", busy, 0);

        // Randomized runs
        for (int i = 0; i < 6; i++) begin
            set_cfg(5'($urandom_range(1, 31)), $urandom_range(1, 3), $urandom_range(0, 2),
                    $urandom_range(0, 3), $urandom_range(1, 10), $urandom_range(1, 3),
                    $urandom_range(1, 25), $urandom_range(1, 3));
            mode = $urandom_range(0, 2);
            off  = $urandom_range(1, 1500);
            run((mode == 1) ? off : 0, (mode == 2) ? off : 0, mode == 0, t0);
        end

        // Asynchronous reset mid-pulse
        mon_en = 0;
        set_cfg(5'b10101, 3, 1, 1, 10, 1, 20, 1);
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("pre_reset_igbt", igbt, 5'b10101);
        #3 sys_rst_n = 1'b0;
        #1;
        chk("async_reset_igbt", igbt, 0);
        chk("async_reset_busy", busy, 0);
        sys_rst_n = 1'b1;

        chk("igbt_scr_overlap", overlap_seen, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
